// File: rtl/axi_slave_ram_if.sv
// ---------------------------------------------------------------------------
// axi_slave_ram_if
// AXI4-full bus bundle between a burst master (e.g. the dma block) and the
// axi_slave_ram responder.
//   AW channel : S_AXI_AW*  (ID, ADDR, LEN, attribute fields, VALID/READY)
//   W  channel : S_AXI_W*   (ID, DATA, STRB, LAST, VALID/READY)
//   B  channel : S_AXI_B*   (ID, RESP, VALID/READY)
//   AR channel : S_AXI_AR*  (ID, ADDR, LEN, attribute fields, VALID/READY)
//   R  channel : S_AXI_R*   (ID, DATA, RESP, LAST, VALID/READY)
// Modports: slave (the RAM side) and master (the requesting side).
// ---------------------------------------------------------------------------
interface axi_slave_ram_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ID_WIDTH-1:0]     S_AXI_AWID;
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [7:0]              S_AXI_AWLEN;
    logic [2:0]              S_AXI_AWSIZE;
    logic [1:0]              S_AXI_AWBURST;
    logic                    S_AXI_AWLOCK;
    logic [3:0]              S_AXI_AWCACHE;
    logic [2:0]              S_AXI_AWPROT;
    logic [3:0]              S_AXI_AWQOS;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;

    logic [ID_WIDTH-1:0]     S_AXI_WID;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WLAST;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;

    logic [ID_WIDTH-1:0]     S_AXI_BID;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;

    logic [ID_WIDTH-1:0]     S_AXI_ARID;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [7:0]              S_AXI_ARLEN;
    logic [2:0]              S_AXI_ARSIZE;
    logic [1:0]              S_AXI_ARBURST;
    logic                    S_AXI_ARLOCK;
    logic [3:0]              S_AXI_ARCACHE;
    logic [2:0]              S_AXI_ARPROT;
    logic [3:0]              S_AXI_ARQOS;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;

    logic [ID_WIDTH-1:0]     S_AXI_RID;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RLAST;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_slave_ram.sv
// ---------------------------------------------------------------------------
// axi_slave_ram
// AXI4-full responder backed by a simple dual-port, byte-lane-writable RAM of
// 2^MEM_ADDR_BITS words. Every burst is handled as INCR with full-width beats;
// the word index wraps modulo the RAM depth. Read and write channels run
// independently, one outstanding burst each.
// Ports:
//   S_AXI_ACLK    : clock
//   S_AXI_ARESETN : synchronous, active-low reset
//   s_axi         : AXI bus (slave modport of axi_slave_ram_if)
// All bus outputs come straight from registers.
// ---------------------------------------------------------------------------
module axi_slave_ram #(
    parameter int S_AXI_ID_WIDTH   = 1,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int S_AXI_DATA_WIDTH = 128,
    parameter int MEM_ADDR_BITS    = 10
) (
    input  logic           S_AXI_ACLK,
    input  logic           S_AXI_ARESETN,
    axi_slave_ram_if.slave s_axi
);
    localparam int BYTES = S_AXI_DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int DEPTH = 2 ** MEM_ADDR_BITS;
    localparam logic [MEM_ADDR_BITS-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // ------------------------------------------------------------------ write
    wstate_t                   wstate_reg;
    logic [MEM_ADDR_BITS-1:0]  widx_reg;
    logic [7:0]                wlen_reg;
    logic [7:0]                wbeat_reg;
    logic                      werr_reg;
    logic                      awready_reg;
    logic                      wready_reg;
    logic                      bvalid_reg;
    logic [1:0]                bresp_reg;
    logic [S_AXI_ID_WIDTH-1:0] bid_reg;

    logic aw_fire;
    logic w_fire;
    logic w_is_last;
    logic wlast_bad;
    logic mem_we;

    assign aw_fire   = s_axi.S_AXI_AWVALID & awready_reg;
    assign w_fire    = s_axi.S_AXI_WVALID & wready_reg;
    assign w_is_last = (wbeat_reg == wlen_reg);
    // WLAST from the master must agree with our own beat count.
    assign wlast_bad = (s_axi.S_AXI_WLAST != w_is_last);
    // A beat arriving on the reset edge belongs to an abandoned burst.
    assign mem_we    = w_fire & (wstate_reg == W_DATA) & S_AXI_ARESETN;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wstate_reg  <= W_IDLE;
            widx_reg    <= '0;
            wlen_reg    <= '0;
            wbeat_reg   <= '0;
            werr_reg    <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            bid_reg     <= '0;
        end else begin
            case (wstate_reg)
                W_IDLE: begin
                    if (aw_fire) begin
                        bid_reg     <= s_axi.S_AXI_AWID;
                        widx_reg    <= s_axi.S_AXI_AWADDR[OFFS +: MEM_ADDR_BITS];
                        wlen_reg    <= s_axi.S_AXI_AWLEN;
                        wbeat_reg   <= '0;
                        werr_reg    <= 1'b0;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        wstate_reg  <= W_DATA;
                    end else begin
                        awready_reg <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        widx_reg  <= widx_reg + IDX_ONE;
                        wbeat_reg <= wbeat_reg + 8'd1;
                        if (w_is_last) begin
                            // The burst ends by count regardless of WLAST.
                            wready_reg <= 1'b0;
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= (werr_reg | wlast_bad) ? 2'b10 : 2'b00;
                            wstate_reg <= W_RESP;
                        end else begin
                            werr_reg <= werr_reg | wlast_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wstate_reg  <= W_IDLE;
                    end
                end
                default: wstate_reg <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    rstate_t                   rstate_reg;
    logic [MEM_ADDR_BITS-1:0]  ridx_reg;      // index of the next word to fetch
    logic [7:0]                rlen_reg;
    logic [7:0]                rbeat_reg;
    logic                      arready_reg;
    logic                      rvalid_reg;
    logic                      rlast_reg;
    logic [S_AXI_ID_WIDTH-1:0] rid_reg;

    logic                      ar_fire;
    logic                      r_fire;
    logic [MEM_ADDR_BITS-1:0]  ar_idx;
    logic                      rd_en;
    logic [MEM_ADDR_BITS-1:0]  rd_idx;

    assign ar_fire = s_axi.S_AXI_ARVALID & arready_reg;
    assign r_fire  = s_axi.S_AXI_RREADY & rvalid_reg;
    assign ar_idx  = s_axi.S_AXI_ARADDR[OFFS +: MEM_ADDR_BITS];
    // The read register only advances when a beat is consumed, so RDATA
    // holds while the master stalls.
    assign rd_en   = ar_fire | (r_fire & ~rlast_reg);
    assign rd_idx  = ar_fire ? ar_idx : ridx_reg;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rstate_reg  <= R_IDLE;
            ridx_reg    <= '0;
            rlen_reg    <= '0;
            rbeat_reg   <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rid_reg     <= '0;
        end else begin
            case (rstate_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_reg     <= s_axi.S_AXI_ARID;
                        rlen_reg    <= s_axi.S_AXI_ARLEN;
                        rbeat_reg   <= '0;
                        ridx_reg    <= ar_idx + IDX_ONE;
                        arready_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        rlast_reg   <= (s_axi.S_AXI_ARLEN == 8'd0);
                        rstate_reg  <= R_DATA;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            rstate_reg  <= R_IDLE;
                        end else begin
                            ridx_reg  <= ridx_reg + IDX_ONE;
                            rbeat_reg <= rbeat_reg + 8'd1;
                            rlast_reg <= ((rbeat_reg + 8'd1) == rlen_reg);
                        end
                    end
                end
                default: rstate_reg <= R_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------- RAM
    // One narrow RAM per byte lane gives per-byte write enables. The read
    // register samples before the write lands, so a same-cycle collision
    // returns the old word.
    logic [S_AXI_DATA_WIDTH-1:0] rdata_bus;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge S_AXI_ACLK) begin
                if (mem_we && s_axi.S_AXI_WSTRB[gi])
                    lane_mem[widx_reg] <= s_axi.S_AXI_WDATA[gi*8 +: 8];
                if (!S_AXI_ARESETN)
                    lane_q <= 8'd0;
                else if (rd_en)
                    lane_q <= lane_mem[rd_idx];
            end

            assign rdata_bus[gi*8 +: 8] = lane_q;
        end
    endgenerate

    // ---------------------------------------------------------------- outputs
    assign s_axi.S_AXI_AWREADY = awready_reg;
    assign s_axi.S_AXI_WREADY  = wready_reg;
    assign s_axi.S_AXI_BID     = bid_reg;
    assign s_axi.S_AXI_BRESP   = bresp_reg;
    assign s_axi.S_AXI_BVALID  = bvalid_reg;
    assign s_axi.S_AXI_ARREADY = arready_reg;
    assign s_axi.S_AXI_RID     = rid_reg;
    assign s_axi.S_AXI_RDATA   = rdata_bus;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RLAST   = rlast_reg;
    assign s_axi.S_AXI_RVALID  = rvalid_reg;

    // Attribute fields and address bits outside the word index carry no
    // meaning for this memory.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLOCK,
                             s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWPROT, s_axi.S_AXI_AWQOS,
                             s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARLOCK,
                             s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARQOS,
                             s_axi.S_AXI_WID, s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

endmodule

// File: tb/tb_axi_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_ram
// Directed sequence of AXI bursts with randomized data, IDs, address low
// bits and ready stalls. A word-array model of the RAM, updated from the
// byte strobes of each accepted beat, provides every expected read value.
// ---------------------------------------------------------------------------
module tb_axi_slave_ram;
    localparam int IDW   = 1;
    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int BYTES = DW / 8;
    localparam int MAB   = 10;
    localparam int DEPTH = 2 ** MAB;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    axi_slave_ram_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_slave_ram #(
        .S_AXI_ID_WIDTH(IDW), .S_AXI_ADDR_WIDTH(AW),
        .S_AXI_DATA_WIDTH(DW), .MEM_ADDR_BITS(MAB)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(aresetn),
        .s_axi(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]    model_mem [DEPTH];
    logic [DW-1:0]    wdata_q [$];
    logic [BYTES-1:0] wstrb_q [$];
    logic [DW-1:0]    rd_q [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL timeout_%s: observed no handshake, required one within the cycle bound", tag);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Write burst of len+1 beats from wdata_q/wstrb_q starting at word index.
    // bad_last >= 0 puts WLAST on that beat instead of the last one.
    // rst_beat >= 0 asserts reset while that beat is offered and abandons.
    task automatic axi_write(input int word, input int len, input int bad_last,
                             input int rst_beat, input bit stall, output logic [1:0] resp);
        logic [IDW-1:0] id;
        int cyc;
        int idx;
        resp = 2'bxx;
        id = IDW'($urandom);
        bus.S_AXI_AWID    = id;
        bus.S_AXI_AWADDR  = AW'(word * BYTES) + AW'($urandom_range(0, BYTES - 1));
        bus.S_AXI_AWLEN   = 8'(len);
        bus.S_AXI_AWVALID = 1'b1;
        cyc = 0;
        while (bus.S_AXI_AWREADY !== 1'b1) begin
            @(negedge clk);
            if (++cyc > 200) begin timeout("aw"); bus.S_AXI_AWVALID = 1'b0; return; end
        end
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("wready_after_aw", bus.S_AXI_WREADY, 1);
        for (int b = 0; b <= len; b++) begin
            if (stall && $urandom_range(0, 3) == 0) begin
                bus.S_AXI_WVALID = 1'b0;
                @(negedge clk);
            end
            bus.S_AXI_WDATA  = wdata_q[b];
            bus.S_AXI_WSTRB  = wstrb_q[b];
            bus.S_AXI_WLAST  = (bad_last >= 0) ? (b == bad_last) : (b == len);
            bus.S_AXI_WVALID = 1'b1;
            if (b == rst_beat) begin
                aresetn = 1'b0;
                @(negedge clk);
                bus.S_AXI_WVALID = 1'b0;
                return;
            end
            cyc = 0;
            while (bus.S_AXI_WREADY !== 1'b1) begin
                @(negedge clk);
                if (++cyc > 200) begin timeout("w"); bus.S_AXI_WVALID = 1'b0; return; end
            end
            idx = (word + b) % DEPTH;
            for (int k = 0; k < BYTES; k++)
                if (wstrb_q[b][k]) model_mem[idx][8*k +: 8] = wdata_q[b][8*k +: 8];
            @(negedge clk);
        end
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
        check("bvalid_after_last", bus.S_AXI_BVALID, 1);
        if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.S_AXI_BREADY = 1'b1;
        cyc = 0;
        while (bus.S_AXI_BVALID !== 1'b1) begin
            @(negedge clk);
            if (++cyc > 200) begin timeout("b"); bus.S_AXI_BREADY = 1'b0; return; end
        end
        resp = bus.S_AXI_BRESP;
        check("bid", bus.S_AXI_BID, id);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check("bvalid_drop", bus.S_AXI_BVALID, 0);
        check("awready_after_b", bus.S_AXI_AWREADY, 1);
        $display("write word=%0d len=%0d bresp=%0b", word, len, resp);
    endtask

    // Read burst of len+1 beats; each beat is compared to the model and
    // collected into rd_q. Without stalls the burst must stream at one beat
    // per cycle.
    task automatic axi_read(input int word, input int len, input bit stall);
        logic [IDW-1:0] id;
        logic [DW-1:0]  held;
        bit             holding;
        int             cyc;
        int             beat;
        rd_q.delete();
        holding = 1'b0;
        beat = 0;
        id = IDW'($urandom);
        bus.S_AXI_ARID    = id;
        bus.S_AXI_ARADDR  = AW'(word * BYTES) + AW'($urandom_range(0, BYTES - 1));
        bus.S_AXI_ARLEN   = 8'(len);
        bus.S_AXI_ARVALID = 1'b1;
        cyc = 0;
        while (bus.S_AXI_ARREADY !== 1'b1) begin
            @(negedge clk);
            if (++cyc > 200) begin timeout("ar"); bus.S_AXI_ARVALID = 1'b0; return; end
        end
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        check("rvalid_after_ar", bus.S_AXI_RVALID, 1);
        cyc = 0;
        while (beat <= len) begin
            bus.S_AXI_RREADY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (holding) check("rdata_hold", bus.S_AXI_RDATA, held);
            if (bus.S_AXI_RVALID !== 1'b1) begin
                check("rvalid_in_burst", bus.S_AXI_RVALID, 1);
                break;
            end
            if (bus.S_AXI_RREADY) begin
                check("rdata", bus.S_AXI_RDATA, model_mem[(word + beat) % DEPTH]);
                check("rlast", bus.S_AXI_RLAST, (beat == len));
                check("rid", bus.S_AXI_RID, id);
                check("rresp", bus.S_AXI_RRESP, 0);
                rd_q.push_back(bus.S_AXI_RDATA);
                beat++;
                holding = 1'b0;
            end else begin
                held = bus.S_AXI_RDATA;
                holding = 1'b1;
            end
            @(negedge clk);
            if (++cyc > 5000) begin timeout("r"); bus.S_AXI_RREADY = 1'b0; return; end
        end
        bus.S_AXI_RREADY = 1'b0;
        check("r_beat_count", rd_q.size(), len + 1);
        check("rvalid_drop", bus.S_AXI_RVALID, 0);
        check("arready_after_r", bus.S_AXI_ARREADY, 1);
        if (!stall) check("r_full_rate_cycles", cyc, len + 1);
        $display("read  word=%0d len=%0d beats=%0d cycles=%0d", word, len, rd_q.size(), cyc);
    endtask

    task automatic fill_random(input int n);
        wdata_q.delete();
        wstrb_q.delete();
        for (int i = 0; i < n; i++) begin
            wdata_q.push_back(rand_word());
            wstrb_q.push_back('1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    resp;
        logic [1:0]    resp2;
        logic [DW-1:0] v;
        logic [DW-1:0] src_snap [$];

        aresetn = 1'b0;
        bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0;
        bus.S_AXI_AWSIZE = 3'd4; bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWLOCK = 1'b0;
        bus.S_AXI_AWCACHE = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWQOS = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WID = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
        bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARSIZE = 3'd4; bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARLOCK = 1'b0;
        bus.S_AXI_ARCACHE = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARQOS = '0;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", bus.S_AXI_AWREADY, 0);
        check("rst_wready",  bus.S_AXI_WREADY,  0);
        check("rst_bvalid",  bus.S_AXI_BVALID,  0);
        check("rst_arready", bus.S_AXI_ARREADY, 0);
        check("rst_rvalid",  bus.S_AXI_RVALID,  0);
        check("rst_rlast",   bus.S_AXI_RLAST,   0);
        check("rst_bresp",   bus.S_AXI_BRESP,   0);
        check("rst_rresp",   bus.S_AXI_RRESP,   0);
        check("rst_bid",     bus.S_AXI_BID,     0);
        check("rst_rid",     bus.S_AXI_RID,     0);
        check("rst_rdata",   bus.S_AXI_RDATA,   0);
        aresetn = 1'b1;
        @(negedge clk);
        check("awready_after_rst", bus.S_AXI_AWREADY, 1);
        check("arready_after_rst", bus.S_AXI_ARREADY, 1);

        // Single-beat write then read at byte address 0x10 (word 1)
        v = {16{8'hA5}};
        wdata_q = '{v};
        wstrb_q = '{'1};
        axi_write(1, 0, -1, -1, 1'b0, resp);
        check("single_bresp", resp, 2'b00);
        axi_read(1, 0, 1'b0);
        check("single_rdata", rd_q[0], v);

        // 256-beat burst, data = beat index, random stalls on both sides
        wdata_q.delete();
        wstrb_q.delete();
        for (int i = 0; i < 256; i++) begin
            wdata_q.push_back(DW'(i));
            wstrb_q.push_back('1);
        end
        axi_write(0, 255, -1, -1, 1'b1, resp);
        check("b256_bresp", resp, 2'b00);
        axi_read(0, 255, 1'b1);
        for (int i = 0; i < 256; i += 51) check("b256_order", rd_q[i], DW'(i));

        // Byte strobes
        wdata_q = '{'1};
        wstrb_q = '{'1};
        axi_write(300, 0, -1, -1, 1'b0, resp);
        wdata_q = '{'0};
        wstrb_q = '{16'h0001};
        axi_write(300, 0, -1, -1, 1'b0, resp);
        axi_read(300, 0, 1'b0);
        v = '1;
        v[7:0] = 8'h00;
        check("strobe_rdata", rd_q[0], v);

        // WLAST on beat 1 of a 4-beat burst, then a correct burst
        fill_random(4);
        axi_write(310, 3, 1, -1, 1'b0, resp);
        check("wlast_err_bresp", resp, 2'b10);
        axi_read(310, 3, 1'b0);
        fill_random(4);
        axi_write(320, 3, -1, -1, 1'b1, resp);
        check("wlast_ok_bresp", resp, 2'b00);

        // Wrap at the top of the RAM with a concurrent full-rate read
        fill_random(16);
        axi_write(400, 15, -1, -1, 1'b0, resp);
        fill_random(4);
        fork
            axi_write(DEPTH - 2, 3, -1, -1, 1'b0, resp2);
            axi_read(400, 15, 1'b0);
        join
        check("wrap_bresp", resp2, 2'b00);
        axi_read(DEPTH - 2, 3, 1'b0);
        check("wrap_word0", rd_q[2], wdata_q[2]);
        check("wrap_word1", rd_q[3], wdata_q[3]);

        // Reset during beat 5 of a 16-beat write
        fill_random(16);
        axi_write(500, 15, -1, 5, 1'b0, resp);
        check("midrst_awready", bus.S_AXI_AWREADY, 0);
        check("midrst_wready",  bus.S_AXI_WREADY,  0);
        check("midrst_bvalid",  bus.S_AXI_BVALID,  0);
        check("midrst_arready", bus.S_AXI_ARREADY, 0);
        check("midrst_rvalid",  bus.S_AXI_RVALID,  0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        check("midrst_awready_back", bus.S_AXI_AWREADY, 1);
        check("midrst_arready_back", bus.S_AXI_ARREADY, 1);
        axi_read(500, 4, 1'b0);

        // DMA-style copy of 300 words (256 + 44) from word 0 to word 600
        fill_random(256);
        axi_write(0, 255, -1, -1, 1'b1, resp);
        fill_random(44);
        axi_write(256, 43, -1, -1, 1'b1, resp);
        src_snap.delete();
        for (int i = 0; i < 300; i++) src_snap.push_back(model_mem[i]);
        axi_read(0, 255, 1'b1);
        wdata_q = rd_q;
        wstrb_q.delete();
        for (int i = 0; i < 256; i++) wstrb_q.push_back('1);
        axi_write(600, 255, -1, -1, 1'b1, resp);
        axi_read(256, 43, 1'b1);
        wdata_q = rd_q;
        wstrb_q.delete();
        for (int i = 0; i < 44; i++) wstrb_q.push_back('1);
        axi_write(856, 43, -1, -1, 1'b1, resp);
        axi_read(600, 255, 1'b0);
        for (int i = 0; i < 256; i += 37) check("dma_copy", rd_q[i], src_snap[i]);
        axi_read(856, 43, 1'b0);
        check("dma_copy_tail", rd_q[43], src_snap[299]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
